// File: rtl/tb_exit_pkg.sv
// Shared types for the end-of-test monitor: FSM states, per-channel verdicts
// and the helper that turns a report into a verdict.
package tb_exit_pkg;

  localparam int EXIT_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  typedef enum logic [1:0] {V_NONE, V_PASS, V_FAIL} verdict_e;

  // A non-zero exit code counts as a failure just like an explicit failed pulse.
  function automatic verdict_e judge(input logic failed,
                                     input logic exit_valid,
                                     input logic [EXIT_W-1:0] exit_value);
    return (failed || (exit_valid && (exit_value != '0))) ? V_FAIL : V_PASS;
  endfunction

endpackage

// File: rtl/tb_exit_channel.sv
// One reporting channel: latches the first pass/fail/exit event while enabled
// and holds its verdict and exit value until reset.
module tb_exit_channel
  import tb_exit_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              passed_i,
  input  logic              failed_i,
  input  logic              exit_valid_i,
  input  logic [EXIT_W-1:0] exit_value_i,
  output logic              reported_o,
  output logic              fail_o,
  output logic              fail_evt_o,
  output logic [EXIT_W-1:0] exit_value_o
);

  verdict_e          verdict_reg;
  logic [EXIT_W-1:0] value_reg;
  logic              fresh;
  logic              evt;

  assign fresh = en_i && (verdict_reg == V_NONE);
  assign evt   = passed_i || failed_i || exit_valid_i;

  // Tells the top a failure is being latched this cycle, for first-fail ordering.
  assign fail_evt_o = fresh && (failed_i || (exit_valid_i && (exit_value_i != '0)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      verdict_reg <= V_NONE;
      value_reg   <= '0;
    end else if (fresh && evt) begin
      verdict_reg <= judge(failed_i, exit_valid_i, exit_value_i);
      // A failed pulse outranks a same-cycle exit, so its code is not kept.
      value_reg   <= (exit_valid_i && !failed_i) ? exit_value_i : '0;
    end
  end

  assign reported_o   = (verdict_reg != V_NONE);
  assign fail_o       = (verdict_reg == V_FAIL);
  assign exit_value_o = value_reg;

endmodule

// File: rtl/tb_exit_monitor.sv
// Multi-channel end-of-test monitor and watchdog: collects channel reports,
// enforces a cycle limit, drains, then raises one sticky verdict.
module tb_exit_monitor
  import tb_exit_pkg::*;
#(
  parameter int NUM_CH       = 1,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 0,
  parameter int FAIL_FAST    = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic [CNT_W-1:0]           max_cycles_i,
  input  logic [NUM_CH-1:0]          ch_passed_i,
  input  logic [NUM_CH-1:0]          ch_failed_i,
  input  logic [NUM_CH-1:0]          ch_exit_valid_i,
  input  logic [NUM_CH*EXIT_W-1:0]   ch_exit_value_i,
  output logic                       done_o,
  output logic                       all_passed_o,
  output logic                       timeout_o,
  output logic [NUM_CH-1:0]          reported_o,
  output logic [NUM_CH-1:0]          fail_mask_o,
  output logic [$clog2(NUM_CH):0]    first_fail_o,
  output logic [EXIT_W-1:0]          exit_value_o,
  output logic [CNT_W-1:0]           cycle_cnt_o
);

  localparam int FF_W       = $clog2(NUM_CH) + 1;
  localparam int DW         = $clog2(DRAIN_CYCLES + 2);
  localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam logic [FF_W-1:0] FF_NONE = FF_W'(1) << (FF_W - 1);

  state_e            state_reg;
  logic [DW-1:0]     drain_cnt_reg;
  logic              ch_en;
  logic [NUM_CH-1:0] fail_evt;
  logic [EXIT_W-1:0] ch_value [NUM_CH];
  logic [FF_W-1:0]   ff_sel;
  logic              hit_limit;
  logic              run_end;

  assign ch_en = (state_reg == RUN) || (state_reg == DRAIN);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      tb_exit_channel u_ch (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (ch_en),
        .passed_i     (ch_passed_i[gi]),
        .failed_i     (ch_failed_i[gi]),
        .exit_valid_i (ch_exit_valid_i[gi]),
        .exit_value_i (ch_exit_value_i[gi*EXIT_W +: EXIT_W]),
        .reported_o   (reported_o[gi]),
        .fail_o       (fail_mask_o[gi]),
        .fail_evt_o   (fail_evt[gi]),
        .exit_value_o (ch_value[gi])
      );
    end
  endgenerate

  // Lowest-index failing channel in the current cycle; scanned high to low so low wins.
  always_comb begin
    ff_sel = FF_NONE;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (fail_evt[k]) ff_sel = FF_W'(k);
    end
  end

  // Exit code follows first_fail_o; the "none" encoding matches no channel and yields 0.
  always_comb begin
    exit_value_o = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (first_fail_o == FF_W'(k)) exit_value_o = ch_value[k];
    end
  end

  assign hit_limit = (max_cycles_i != '0) && (cycle_cnt_o >= max_cycles_i);
  assign run_end   = (&reported_o) || ((FAIL_FAST != 0) && (|fail_mask_o)) || hit_limit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      drain_cnt_reg <= '0;
      done_o        <= 1'b0;
      timeout_o     <= 1'b0;
      cycle_cnt_o   <= '0;
      first_fail_o  <= FF_NONE;
    end else begin
      if (first_fail_o[FF_W-1] && (fail_evt != '0)) first_fail_o <= ff_sel;
      case (state_reg)
        IDLE: begin
          if (enable_i) state_reg <= RUN;
        end
        RUN: begin
          // The exit edge does not count, so a timeout reports exactly the limit.
          if (run_end) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= '0;
            if (hit_limit) timeout_o <= 1'b1;
          end else if (cycle_cnt_o != '1) begin
            cycle_cnt_o <= cycle_cnt_o + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == DW'(DRAIN_LAST)) begin
            state_reg <= DONE;
            done_o    <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 1'b1;
          end
        end
        DONE: ;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign all_passed_o = done_o && !timeout_o && (&reported_o) && !(|fail_mask_o);

endmodule

// File: tb/tb_tb_exit_monitor.sv
// Directed bench for tb_exit_monitor: four instances in different configurations
// share one stimulus bus; each test checks the instance it targets.
module tb_tb_exit_monitor;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic [31:0]  max_cycles = '0;
  logic [3:0]   passed = '0;
  logic [3:0]   failed = '0;
  logic [3:0]   exv = '0;
  logic [127:0] exval = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // a_*: NUM_CH=1
  logic a_done, a_allp, a_to, a_rep, a_fail, a_ff;
  logic [31:0] a_ev, a_cnt;
  // b_*: NUM_CH=4, FAIL_FAST=0, DRAIN_CYCLES=0
  logic b_done, b_allp, b_to;
  logic [3:0] b_rep, b_fail;
  logic [2:0] b_ff;
  logic [31:0] b_ev, b_cnt;
  // c_*: NUM_CH=4, FAIL_FAST=1
  logic c_done, c_allp, c_to;
  logic [3:0] c_rep, c_fail;
  logic [2:0] c_ff;
  logic [31:0] c_ev, c_cnt;
  // d_*: NUM_CH=4, DRAIN_CYCLES=3
  logic d_done, d_allp, d_to;
  logic [3:0] d_rep, d_fail;
  logic [2:0] d_ff;
  logic [31:0] d_ev, d_cnt;

  tb_exit_monitor #(.NUM_CH(1)) u_a (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .max_cycles_i(max_cycles),
    .ch_passed_i(passed[0:0]), .ch_failed_i(failed[0:0]), .ch_exit_valid_i(exv[0:0]),
    .ch_exit_value_i(exval[31:0]),
    .done_o(a_done), .all_passed_o(a_allp), .timeout_o(a_to), .reported_o(a_rep),
    .fail_mask_o(a_fail), .first_fail_o(a_ff), .exit_value_o(a_ev), .cycle_cnt_o(a_cnt)
  );

  tb_exit_monitor #(.NUM_CH(4)) u_b (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .max_cycles_i(max_cycles),
    .ch_passed_i(passed), .ch_failed_i(failed), .ch_exit_valid_i(exv),
    .ch_exit_value_i(exval),
    .done_o(b_done), .all_passed_o(b_allp), .timeout_o(b_to), .reported_o(b_rep),
    .fail_mask_o(b_fail), .first_fail_o(b_ff), .exit_value_o(b_ev), .cycle_cnt_o(b_cnt)
  );

  tb_exit_monitor #(.NUM_CH(4), .FAIL_FAST(1)) u_c (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .max_cycles_i(max_cycles),
    .ch_passed_i(passed), .ch_failed_i(failed), .ch_exit_valid_i(exv),
    .ch_exit_value_i(exval),
    .done_o(c_done), .all_passed_o(c_allp), .timeout_o(c_to), .reported_o(c_rep),
    .fail_mask_o(c_fail), .first_fail_o(c_ff), .exit_value_o(c_ev), .cycle_cnt_o(c_cnt)
  );

  tb_exit_monitor #(.NUM_CH(4), .DRAIN_CYCLES(3)) u_d (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .max_cycles_i(max_cycles),
    .ch_passed_i(passed), .ch_failed_i(failed), .ch_exit_valid_i(exv),
    .ch_exit_value_i(exval),
    .done_o(d_done), .all_passed_o(d_allp), .timeout_o(d_to), .reported_o(d_rep),
    .fail_mask_o(d_fail), .first_fail_o(d_ff), .exit_value_o(d_ev), .cycle_cnt_o(d_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    passed = '0;
    failed = '0;
    exv    = '0;
    exval  = '0;
  endtask

  // Reset lands between clock edges so the checks show it acting asynchronously.
  task automatic do_reset(input string tag);
    #3;
    rst = 1'b1;
    enable = 1'b0;
    clr();
    #1;
    check({tag, "_rst_done"}, b_done, 0);
    check({tag, "_rst_cnt"}, b_cnt, 0);
    check({tag, "_rst_ff"}, b_ff, 3'b100);
    check({tag, "_rst_rep"}, b_rep, 0);
    check({tag, "_rst_to"}, b_to, 0);
    check({tag, "_rst_a_ff"}, a_ff, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic start();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // T1: single channel, pass reported while cycle count is 10
    do_reset("t1");
    start();
    repeat (10) tick();
    check("t1_cnt10", a_cnt, 10);
    passed[0] = 1'b1;
    tick();
    clr();
    check("t1_rep", a_rep, 1);
    check("t1_cnt11", a_cnt, 11);
    tick();
    check("t1_drain_done", a_done, 0);
    tick();
    check("t1_done", a_done, 1);
    check("t1_allp", a_allp, 1);
    check("t1_cnt_final", a_cnt, 11);
    check("t1_to", a_to, 0);
    check("t1_ff", a_ff, 1);

    // T2: ch2 exits 5 at c3, ch0 passes at c4, ch1/ch3 exit 0 at c6
    do_reset("t2");
    start();
    repeat (3) tick();
    exv[2] = 1'b1;
    exval[95:64] = 32'd5;
    tick();
    clr();
    passed[0] = 1'b1;
    tick();
    clr();
    check("t2_fail_mid", b_fail, 4'b0100);
    check("t2_ff_mid", b_ff, 2);
    check("t2_ev_mid", b_ev, 5);
    check("t2_rep_mid", b_rep, 4'b0101);
    tick();
    exv[1] = 1'b1;
    exv[3] = 1'b1;
    tick();
    clr();
    check("t2_rep_all", b_rep, 4'b1111);
    tick();
    check("t2_drain_done", b_done, 0);
    tick();
    check("t2_done", b_done, 1);
    check("t2_fail", b_fail, 4'b0100);
    check("t2_ff", b_ff, 2);
    check("t2_ev", b_ev, 5);
    check("t2_allp", b_allp, 0);
    check("t2_cnt", b_cnt, 7);

    // T3: fail-fast; ch1 (failed + exit 7) and ch3 failed in the same cycle
    do_reset("t3");
    start();
    repeat (2) tick();
    failed[1] = 1'b1;
    failed[3] = 1'b1;
    exv[1] = 1'b1;
    exval[63:32] = 32'd7;
    tick();
    clr();
    check("t3_fail", c_fail, 4'b1010);
    check("t3_ff", c_ff, 1);
    check("t3_ev", c_ev, 0);
    check("t3_rep", c_rep, 4'b1010);
    tick();
    check("t3_drain_done", c_done, 0);
    tick();
    check("t3_done", c_done, 1);
    check("t3_cnt", c_cnt, 3);
    check("t3_allp", c_allp, 0);
    check("t3_rep_final", c_rep, 4'b1010);
    check("t3_nonff_done", b_done, 0);

    // T4: cycle limit 100, no reports
    do_reset("t4");
    max_cycles = 32'd100;
    start();
    n = 0;
    while (!b_done && n < 200) begin
      tick();
      n++;
    end
    check("t4_cycles_to_done", n, 102);
    check("t4_done", b_done, 1);
    check("t4_to", b_to, 1);
    check("t4_cnt", b_cnt, 100);
    check("t4_allp", b_allp, 0);
    check("t4_rep", b_rep, 0);

    // T5: drain of 3; timeout at 5, late exit 9 on ch2 during drain still latches
    do_reset("t5");
    max_cycles = 32'd5;
    start();
    tick();
    passed[0] = 1'b1;
    passed[1] = 1'b1;
    tick();
    clr();
    repeat (3) tick();
    check("t5_to_before", d_to, 0);
    tick();
    check("t5_to", d_to, 1);
    check("t5_cnt", d_cnt, 5);
    exv[2] = 1'b1;
    exval[95:64] = 32'd9;
    tick();
    clr();
    check("t5_fail", d_fail, 4'b0100);
    check("t5_ff", d_ff, 2);
    check("t5_ev", d_ev, 9);
    check("t5_rep", d_rep, 4'b0111);
    check("t5_done_early", d_done, 0);
    tick();
    check("t5_done_early2", d_done, 0);
    tick();
    check("t5_done", d_done, 1);
    check("t5_allp", d_allp, 0);
    failed[3] = 1'b1;
    tick();
    clr();
    check("t5_frozen_rep", d_rep, 4'b0111);
    check("t5_frozen_fail", d_fail, 4'b0100);

    // T6: repeated pulse after first report, then reset mid-RUN, then IDLE ignores reports
    do_reset("t6");
    max_cycles = 32'd0;
    start();
    tick();
    passed[0] = 1'b1;
    tick();
    clr();
    check("t6_rep", b_rep, 4'b0001);
    failed[0] = 1'b1;
    exv[0] = 1'b1;
    exval[31:0] = 32'd3;
    tick();
    clr();
    check("t6_rep_again", b_rep, 4'b0001);
    check("t6_fail_again", b_fail, 0);
    check("t6_ff_again", b_ff, 3'b100);
    check("t6_cnt", b_cnt, 3);
    do_reset("t6_mid");
    passed = 4'b1111;
    tick();
    clr();
    check("t6_idle_rep", b_rep, 0);
    check("t6_idle_cnt", b_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
